// File: rtl/tdpram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between NUM_REQ clients, with tagged read return.
// Define TDPRAM_ARB_PERF_CNT_EN to add saturating grant/stall performance counters.
module tdpram_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LAT     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           ram_we,
    output logic [ADDR_WIDTH-1:0]          ram_addr,
    output logic [DATA_WIDTH-1:0]          ram_din,
    input  logic [DATA_WIDTH-1:0]          ram_dout
`ifdef TDPRAM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]                    perf_grant_cnt,
    output logic [31:0]                    perf_stall_cnt
`endif
);

    localparam int REQ_W = $clog2(NUM_REQ);

    logic [REQ_W-1:0]      ptr_q, ptr_d;
    logic [REQ_W-1:0]      idx, gnt_id;
    logic                  hs;
    logic                  ram_we_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [DATA_WIDTH-1:0] ram_din_q;
    logic [RD_LAT:0]       pv_q;
    logic [REQ_W-1:0]      pid_q [RD_LAT+1];

    // Search starts at the priority pointer; first valid requester wins.
    always_comb begin
        req_ready = '0;
        hs        = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = REQ_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!hs && req_valid[idx]) begin
                hs             = 1'b1;
                gnt_id         = idx;
                req_ready[idx] = 1'b1;
            end
        end
        ptr_d = ptr_q;
        if (hs) begin
            ptr_d = (gnt_id == REQ_W'(NUM_REQ - 1)) ? '0 : gnt_id + REQ_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            pv_q       <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                pid_q[k] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            ram_we_q <= hs & req_we[gnt_id];
            if (hs) begin
                ram_addr_q <= req_addr[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
                ram_din_q  <= req_wdata[gnt_id*DATA_WIDTH +: DATA_WIDTH];
            end
            pv_q     <= {pv_q[RD_LAT-1:0], hs & ~req_we[gnt_id]};
            pid_q[0] <= gnt_id;
            for (int k = 1; k <= RD_LAT; k++) begin
                pid_q[k] <= pid_q[k-1];
            end
        end
    end

    // Last pipe stage lines up with the RAM's registered read data.
    always_comb begin
        rsp_valid = '0;
        if (pv_q[RD_LAT]) begin
            rsp_valid[pid_q[RD_LAT]] = 1'b1;
        end
    end

    assign rsp_rdata = ram_dout;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;

`ifdef TDPRAM_ARB_PERF_CNT_EN
    logic [31:0] grant_cnt_q, stall_cnt_q;
    logic        multi;

    assign multi = |(req_valid & (req_valid - NUM_REQ'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (hs && grant_cnt_q != '1) begin
                grant_cnt_q <= grant_cnt_q + 32'd1;
            end
            if (multi && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_grant_cnt = grant_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tdpram_port_arbiter.sv
// Scoreboard bench: two arbiters (RD_LAT 1 and 2) share directed stimulus,
// each with its own RAM model; a negedge monitor checks grants, commands and responses.
module tb_tdpram_port_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_we;
    logic [39:0] req_addr;
    logic [31:0] req_wdata;

    logic [3:0]  rdy0, rdy1, rv0, rv1;
    logic [7:0]  rd0, rd1;
    logic        we0, we1;
    logic [9:0]  addr0, addr1;
    logic [7:0]  din0, din1;
    logic [7:0]  dout0, dout1, dout1_a;
`ifdef TDPRAM_ARB_PERF_CNT_EN
    logic [31:0] pg0, ps0, pg1, ps1;
`endif

    tdpram_port_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(10), .RD_LAT(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(rdy0), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_rdata(rd0),
        .ram_we(we0), .ram_addr(addr0), .ram_din(din0), .ram_dout(dout0)
`ifdef TDPRAM_ARB_PERF_CNT_EN
        , .perf_grant_cnt(pg0), .perf_stall_cnt(ps0)
`endif
    );

    tdpram_port_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(10), .RD_LAT(2)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_rdata(rd1),
        .ram_we(we1), .ram_addr(addr1), .ram_din(din1), .ram_dout(dout1)
`ifdef TDPRAM_ARB_PERF_CNT_EN
        , .perf_grant_cnt(pg1), .perf_stall_cnt(ps1)
`endif
    );

    logic [7:0] mem0 [1024];
    logic [7:0] mem1 [1024];

    always @(posedge clk) begin
        if (we0) mem0[addr0] <= din0;
        dout0 <= mem0[addr0];
    end

    always @(posedge clk) begin
        if (we1) mem1[addr1] <= din1;
        dout1_a <= mem1[addr1];
        dout1   <= dout1_a;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        int         due;
    } rsp_t;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
    } chk_t;

    rsp_t q0[$];
    rsp_t q1[$];
    chk_t cq[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic chk_lane(input int lane, input logic [3:0] rv, input logic [7:0] rd);
        rsp_t       e;
        bit         have;
        logic [3:0] erv;
        have = 1'b0;
        if (lane == 0 && q0.size() > 0) begin e = q0[0]; have = 1'b1; end
        if (lane == 1 && q1.size() > 0) begin e = q1[0]; have = 1'b1; end
        if (rv != 4'b0) begin
            checks++;
            if (!have) begin
                fails++;
                $display("FAIL rsp_unexpected lane%0d cyc=%0d got rsp_valid=%b want none", lane, cyc, rv);
            end else begin
                if (lane == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                erv = 4'b0;
                erv[e.id] = 1'b1;
                if (rv !== erv || rd !== e.data || cyc != e.due) begin
                    fails++;
                    $display("FAIL rsp lane%0d got valid=%b data=%h cyc=%0d want valid=%b data=%h cyc=%0d",
                             lane, rv, rd, cyc, erv, e.data, e.due);
                end
            end
        end else if (have && e.due <= cyc) begin
            checks++;
            fails++;
            if (lane == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            $display("FAIL rsp_missing lane%0d cyc=%0d got none want id=%0d due=%0d", lane, cyc, e.id, e.due);
        end
    endtask

    always @(negedge clk) begin
        chk_t        c;
        logic [63:0] act, exp;
        string       nm;
        while (cq.size() > 0) begin
            c   = cq.pop_front();
            act = '0;
            exp = '0;
            nm  = "";
            case (c.kind)
                0: begin
                    nm  = "grant";
                    act = {56'b0, rdy1, rdy0};
                    exp = {56'b0, c.a[3:0], c.a[3:0]};
                end
                1: begin
                    nm  = "ram_cmd";
                    act = {26'b0, we1, addr1, din1, we0, addr0, din0};
                    exp = {26'b0, c.a[18:0], c.a[18:0]};
                end
                2: begin
                    nm  = "reset_outputs";
                    act = {2'b0, rdy0, rdy1, rv0, rv1, we0, we1, addr0, addr1, din0, din1, rd0 & 8'h0};
`ifdef TDPRAM_ARB_PERF_CNT_EN
                    if ((pg0 | ps0 | pg1 | ps1) != 32'd0) act[63] = 1'b1;
`endif
                end
                3: begin
                    nm = "perf_cnt";
`ifdef TDPRAM_ARB_PERF_CNT_EN
                    act = {pg0, ps0};
`endif
                    exp = {c.a, c.b};
                end
                4: begin
                    nm  = "rsp_quiet";
                    act = {56'b0, rv1, rv0};
                end
                default: begin
                    nm  = "queues_empty";
                    act = 64'(q0.size() + q1.size());
                end
            endcase
            checks++;
            if (act !== exp) begin
                fails++;
                $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
            end
        end
        chk_lane(0, rv0, rd0);
        chk_lane(1, rv1, rd1);
    end

    task automatic set_req(input int i, input logic [9:0] a, input logic [7:0] d);
        req_addr[i*10 +: 10] = a;
        req_wdata[i*8 +: 8]  = d;
    endtask

    task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b);
        chk_t c;
        c.kind = kind;
        c.a    = a;
        c.b    = b;
        cq.push_back(c);
    endtask

    task automatic step(input logic [3:0] v, input logic [3:0] we,
                        input logic [3:0] gnt, input logic [7:0] rd);
        rsp_t e;
        req_valid = v;
        req_we    = we;
        push(0, {28'b0, gnt}, 0);
        if (gnt != 4'b0 && (we & gnt) == 4'b0) begin
            for (int i = 0; i < 4; i++) begin
                if (gnt[i]) e.id = 2'(i);
            end
            e.data = rd;
            e.due  = cyc + 2;
            q0.push_back(e);
            e.due  = cyc + 3;
            q1.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        @(posedge clk);
        #1;
        push(2, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 4; i++) set_req(i, 10'(32'h100 + i), 8'(32'h10 + i));
        step(4'hF, 4'hF, 4'b0001, 8'h00);
        step(4'hF, 4'hF, 4'b0010, 8'h00);
        step(4'hF, 4'hF, 4'b0100, 8'h00);
        step(4'hF, 4'hF, 4'b1000, 8'h00);
        step(4'hF, 4'h0, 4'b0001, 8'h10);
        step(4'hF, 4'h0, 4'b0010, 8'h11);
        step(4'hF, 4'h0, 4'b0100, 8'h12);
        step(4'hF, 4'h0, 4'b1000, 8'h13);

        set_req(0, 10'h010, 8'hA5);
        step(4'b0001, 4'b0001, 4'b0001, 8'h00);
        push(1, {13'b0, 1'b1, 10'h010, 8'hA5}, 0);
        step(4'b0001, 4'b0000, 4'b0001, 8'hA5);
        step(4'b0000, 4'b0000, 4'b0000, 8'h00);
        push(1, {13'b0, 1'b0, 10'h010, 8'hA5}, 0);

        set_req(1, 10'h0F0, 8'h77);
        step(4'b0010, 4'b0010, 4'b0010, 8'h00);
        set_req(1, 10'h101, 8'h11);
        step(4'b1010, 4'b0000, 4'b1000, 8'h13);
        step(4'b0010, 4'b0000, 4'b0010, 8'h11);
        step(4'b1111, 4'b0000, 4'b0100, 8'h12);

        step(4'b0100, 4'b0000, 4'b0100, 8'h12);
        step(4'b0001, 4'b0000, 4'b0001, 8'hA5);
        step(4'b0010, 4'b0000, 4'b0010, 8'h11);
        repeat (5) step(4'b0000, 4'b0000, 4'b0000, 8'h00);

        step(4'b0100, 4'b0000, 4'b0100, 8'h12);
        step(4'b1000, 4'b0000, 4'b1000, 8'h13);
        step(4'b0001, 4'b0000, 4'b0001, 8'hA5);
        rst       = 1'b1;
        req_valid = '0;
        q0.delete();
        q1.delete();
        push(2, 0, 0);
        @(posedge clk);
        #1;
        push(2, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            push(4, 0, 0);
            step(4'b0000, 4'b0000, 4'b0000, 8'h00);
        end

        set_req(0, 10'h010, 8'hA5);
        repeat (5) begin
            step(4'b0011, 4'b0011, 4'b0001, 8'h00);
            step(4'b0011, 4'b0011, 4'b0010, 8'h00);
        end
`ifdef TDPRAM_ARB_PERF_CNT_EN
        push(3, 32'd10, 32'd10);
`endif
        repeat (4) step(4'b0000, 4'b0000, 4'b0000, 8'h00);
        push(5, 0, 0);
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
